// File: rtl/apb_pkg.sv
// -----------------------------------------------------------------------------
// apb_pkg
// Shared declarations for the APB master slice:
//   apb_state_t    - transfer FSM state (IDLE, SETUP, ACCESS, DONE)
//   APB_ADDR_W     - default address width
//   APB_DATA_W     - default data width
//   OP_APB_WR/RD   - control-unit opcodes that hand a transfer to the APB master
//   is_apb_op()    - true for either APB opcode
// -----------------------------------------------------------------------------
package apb_pkg;

  localparam int unsigned APB_ADDR_W = 8;
  localparam int unsigned APB_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } apb_state_t;

  localparam logic [3:0] OP_APB_WR = 4'b1100;
  localparam logic [3:0] OP_APB_RD = 4'b0001;

  function automatic logic is_apb_op(input logic [3:0] op);
    return (op == OP_APB_WR) || (op == OP_APB_RD);
  endfunction

endpackage

// File: rtl/apb_wait_timer.sv
// -----------------------------------------------------------------------------
// apb_wait_timer
// Counts APB wait states and flags when the wait budget is used up.
// Ports:
//   clk      in  clock
//   rst_n    in  asynchronous active-low reset (count -> 0)
//   clr      in  synchronous clear (priority over en)
//   en       in  count one wait cycle
//   expired  out count has reached TIMEOUT-1 (never asserted when TIMEOUT=0)
// The counter saturates at its maximum value, so it cannot wrap even when
// TIMEOUT=0 disables the abort.
// -----------------------------------------------------------------------------
module apb_wait_timer #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned CW = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = (TIMEOUT == 0) ? '0 : CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] MAXV = '1;

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != MAXV)) begin
      count <= count + CW'(1);
    end
  end

  assign expired = (TIMEOUT != 0) && (count == LAST);

endmodule

// File: rtl/apb_master_fsm.sv
// -----------------------------------------------------------------------------
// apb_master_fsm
// APB3 master driven by the CPU control unit: one start request becomes one
// complete APB transfer, with read data/status returned and a one-cycle ready
// pulse back to the control unit. Wait states are bounded by TIMEOUT.
// Ports:
//   PCLK, PRESETn          clock, asynchronous active-low reset
//   start                  transfer request (level, sampled in IDLE only)
//   apb_write              1 = write, 0 = read (sampled with start)
//   req_addr, req_wdata    transfer address / write data (sampled with start)
//   ready                  one-cycle completion pulse
//   rsp_rdata              last successfully read data
//   rsp_err                status of last completed transfer (PSLVERR or timeout)
//   PSEL, PENABLE, PWRITE,
//   PADDR, PWDATA          APB request signals (all registered)
//   PRDATA, PREADY, PSLVERR APB response signals
// -----------------------------------------------------------------------------
module apb_master_fsm
  import apb_pkg::*;
#(
  parameter int unsigned ADDR_W  = APB_ADDR_W,
  parameter int unsigned DATA_W  = APB_DATA_W,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              start,
  input  logic              apb_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY,
  input  logic              PSLVERR
);

  apb_state_t state;

  logic timer_clr;
  logic timer_en;
  logic timer_expired;

  // Timer restarts on every launch and only counts ACCESS cycles with PREADY low.
  assign timer_clr = (state == IDLE) && start;
  assign timer_en  = (state == ACCESS) && !PREADY;

  apb_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .clk     (PCLK),
    .rst_n   (PRESETn),
    .clr     (timer_clr),
    .en      (timer_en),
    .expired (timer_expired)
  );

  // Outputs are assigned together with the next state so that each output
  // register already holds the value belonging to the state being entered.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state     <= IDLE;
      ready     <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      PSEL      <= 1'b0;
      PENABLE   <= 1'b0;
      PWRITE    <= 1'b0;
      PADDR     <= '0;
      PWDATA    <= '0;
    end else begin
      ready <= 1'b0;
      case (state)
        IDLE: begin
          PSEL    <= 1'b0;
          PENABLE <= 1'b0;
          if (start) begin
            PWRITE <= apb_write;
            PADDR  <= req_addr;
            PWDATA <= req_wdata;
            PSEL   <= 1'b1;
            state  <= SETUP;
          end
        end

        SETUP: begin
          PENABLE <= 1'b1;
          state   <= ACCESS;
        end

        ACCESS: begin
          if (PREADY) begin
            rsp_err <= PSLVERR;
            if (!PWRITE && !PSLVERR) begin
              rsp_rdata <= PRDATA;
            end
            PSEL    <= 1'b0;
            PENABLE <= 1'b0;
            ready   <= 1'b1;
            state   <= DONE;
          end else if (timer_expired) begin
            // Abort: report an error, keep the previous read data.
            rsp_err <= 1'b1;
            PSEL    <= 1'b0;
            PENABLE <= 1'b0;
            ready   <= 1'b1;
            state   <= DONE;
          end
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          PSEL    <= 1'b0;
          PENABLE <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master_fsm.sv
module tb_apb_master_fsm;

  localparam int AW = 8;
  localparam int DW = 8;
  localparam int TO = 15;

  logic          PCLK = 1'b0;
  logic          PRESETn;
  logic          start;
  logic          apb_write;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          ready;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          PSEL;
  logic          PENABLE;
  logic          PWRITE;
  logic [AW-1:0] PADDR;
  logic [DW-1:0] PWDATA;
  logic [DW-1:0] PRDATA;
  logic          PREADY;
  logic          PSLVERR;

  int total = 0;
  int bad   = 0;

  // Reference view of the response registers.
  logic [DW-1:0] m_rdata;
  logic          m_err;

  apb_master_fsm #(
    .ADDR_W  (AW),
    .DATA_W  (DW),
    .TIMEOUT (TO)
  ) dut (
    .PCLK      (PCLK),
    .PRESETn   (PRESETn),
    .start     (start),
    .apb_write (apb_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .ready     (ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .PSEL      (PSEL),
    .PENABLE   (PENABLE),
    .PWRITE    (PWRITE),
    .PADDR     (PADDR),
    .PWDATA    (PWDATA),
    .PRDATA    (PRDATA),
    .PREADY    (PREADY),
    .PSLVERR   (PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One transfer against a slave that inserts 'waits' low-PREADY cycles.
  // Expected timeline is counted in rising edges from the edge that samples
  // start (edge 1): SETUP, then acc ACCESS cycles, then DONE, then IDLE.
  task automatic xfer(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                      input int waits, input logic err, input logic [DW-1:0] rd);
    int   acc;
    logic abort;
    abort = (TO != 0) && (waits >= TO);
    acc   = abort ? TO : waits + 1;
    @(negedge PCLK);
    start     = 1'b1;
    apb_write = we;
    req_addr  = a;
    req_wdata = wd;
    PREADY    = 1'($urandom);
    PSLVERR   = 1'($urandom);
    PRDATA    = 8'($urandom);
    for (int i = 1; i <= acc + 3; i++) begin
      @(posedge PCLK);
      @(negedge PCLK);
      // start and request inputs are don't-care while busy
      start     = (i < acc + 3) ? 1'($urandom) : 1'b0;
      apb_write = 1'($urandom);
      req_addr  = 8'($urandom);
      req_wdata = 8'($urandom);
      if (i == 1) begin
        chk("setup", 32'({PSEL, PENABLE, ready, PWRITE, PADDR, PWDATA}),
            32'({1'b1, 1'b0, 1'b0, we, a, wd}));
      end else if (i <= acc + 1) begin
        chk("access", 32'({PSEL, PENABLE, ready, PWRITE, PADDR, PWDATA}),
            32'({1'b1, 1'b1, 1'b0, we, a, wd}));
      end else if (i == acc + 2) begin
        if (abort) begin
          m_err = 1'b1;
        end else begin
          m_err = err;
          if (!we && !err) m_rdata = rd;
        end
        chk("done", 32'({PSEL, PENABLE, ready}), 32'({1'b0, 1'b0, 1'b1}));
        chk("rsp", 32'({rsp_err, rsp_rdata}), 32'({m_err, m_rdata}));
      end else begin
        chk("idle", 32'({PSEL, PENABLE, ready, PWRITE, PADDR, PWDATA}),
            32'({1'b0, 1'b0, 1'b0, we, a, wd}));
      end
      // slave response for the coming edge
      if (i >= 2 && i <= acc + 1 && (i - 2) == waits) begin
        PREADY  = 1'b1;
        PSLVERR = err;
        PRDATA  = rd;
      end else if (i >= 2 && i <= acc + 1) begin
        PREADY  = 1'b0;
        PSLVERR = 1'($urandom);
        PRDATA  = 8'($urandom);
      end else begin
        PREADY  = 1'($urandom);
        PSLVERR = 1'($urandom);
        PRDATA  = 8'($urandom);
      end
    end
  endtask

  task automatic reset_mid_access();
    int pulses;
    @(negedge PCLK);
    start = 1'b1; apb_write = 1'b0; req_addr = 8'h77; req_wdata = 8'h11;
    PREADY = 1'b0;
    @(posedge PCLK); @(negedge PCLK);
    start = 1'b0;
    @(posedge PCLK); @(negedge PCLK);
    chk("pre_rst_access", 32'({PSEL, PENABLE}), 32'({1'b1, 1'b1}));
    #2 PRESETn = 1'b0;
    #1;
    m_err   = 1'b0;
    m_rdata = '0;
    chk("async_rst", 32'({PSEL, PENABLE, ready, rsp_err, rsp_rdata, PWRITE, PADDR, PWDATA}), 32'(0));
    @(negedge PCLK); @(negedge PCLK);
    PRESETn = 1'b1;
    PREADY  = 1'b1;
    pulses  = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge PCLK); @(negedge PCLK);
      if (ready || PSEL) pulses++;
    end
    chk("no_ready_after_rst", 32'(pulses), 32'(0));
  endtask

  // start held high: launches on edges 1, 5, 9; ready after edges 3, 7, 11.
  task automatic back_to_back();
    int            pulses;
    logic          prev_we, lat_we;
    logic [AW-1:0] prev_a;
    logic [DW-1:0] prev_wd, rec;
    pulses = 0;
    lat_we = 1'b0;
    rec    = '0;
    @(negedge PCLK);
    start = 1'b1; PREADY = 1'b1; PSLVERR = 1'b0;
    prev_we = 1'($urandom); prev_a = 8'($urandom); prev_wd = 8'($urandom);
    apb_write = prev_we; req_addr = prev_a; req_wdata = prev_wd;
    for (int i = 1; i <= 12; i++) begin
      logic          lw;
      logic [AW-1:0] la;
      logic [DW-1:0] lwd;
      lw = prev_we; la = prev_a; lwd = prev_wd;
      @(posedge PCLK); @(negedge PCLK);
      if (ready) pulses++;
      case ((i - 1) % 4)
        0: begin
          lat_we = lw;
          chk("b2b_latch", 32'({PSEL, PENABLE, PWRITE, PADDR, PWDATA}),
              32'({1'b1, 1'b0, lw, la, lwd}));
        end
        1: begin
          rec    = 8'($urandom);
          PRDATA = rec;
        end
        2: begin
          m_err = 1'b0;
          if (!lat_we) m_rdata = rec;
          chk("b2b_done", 32'({PSEL, ready, rsp_err, rsp_rdata}),
              32'({1'b0, 1'b1, m_err, m_rdata}));
        end
        default: chk("b2b_gap", 32'({PSEL, ready}), 32'(0));
      endcase
      prev_we = 1'($urandom); prev_a = 8'($urandom); prev_wd = 8'($urandom);
      apb_write = prev_we; req_addr = prev_a; req_wdata = prev_wd;
      if (i == 12) start = 1'b0;
    end
    chk("b2b_pulses", 32'(pulses), 32'(3));
  endtask

  initial begin
    PRESETn = 1'b0;
    start = 1'b0; apb_write = 1'b0; req_addr = '0; req_wdata = '0;
    PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;
    m_rdata = '0; m_err = 1'b0;
    #12;
    chk("reset", 32'({PSEL, PENABLE, ready, rsp_err, rsp_rdata, PWRITE, PADDR, PWDATA}), 32'(0));
    @(negedge PCLK); @(negedge PCLK);
    PRESETn = 1'b1;

    xfer(1'b1, 8'h3C, 8'hA5, 0, 1'b0, 8'h00);     // write, zero wait
    xfer(1'b0, 8'h40, 8'h00, 2, 1'b0, 8'h5A);     // read, 2 waits
    xfer(1'b0, 8'h41, 8'h00, 0, 1'b1, 8'hFF);     // read, slave error
    xfer(1'b0, 8'h42, 8'h00, 100, 1'b0, 8'h33);   // stuck slave -> timeout
    xfer(1'b0, 8'h43, 8'h00, TO - 1, 1'b0, 8'h6C); // ready on last allowed cycle
    xfer(1'b1, 8'h44, 8'h99, TO - 1, 1'b1, 8'h00); // write error, no rdata change
    reset_mid_access();
    xfer(1'b0, 8'h50, 8'h00, 1, 1'b0, 8'hC3);     // normal after reset
    back_to_back();
    for (int n = 0; n < 25; n++) begin
      int w;
      w = ($urandom_range(0, 7) == 0) ? int'($urandom_range(TO, TO + 5))
                                      : int'($urandom_range(0, 4));
      xfer(1'($urandom), 8'($urandom), 8'($urandom), w, 1'($urandom), 8'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard stop in case the run itself stalls.
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
